// File: rtl/symm_pad_source_if.sv
// Handshake bundle for symm_pad_source: raw pixel input, padded pixel output.
// o_frame_cnt is present only when PADSRC_FRAME_CNT_EN is defined.
interface symm_pad_source_if;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_x;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_y;
  logic       o_eol;
  logic       o_eof;
`ifdef PADSRC_FRAME_CNT_EN
  logic [15:0] o_frame_cnt;
`endif

  modport master (
    output i_valid, i_x, i_ready,
    input  o_ready, o_valid, o_y, o_eol, o_eof
`ifdef PADSRC_FRAME_CNT_EN
    , input o_frame_cnt
`endif
  );

  modport slave (
    input  i_valid, i_x, i_ready,
    output o_ready, o_valid, o_y, o_eol, o_eof
`ifdef PADSRC_FRAME_CNT_EN
    , output o_frame_cnt
`endif
  );
endinterface

// File: rtl/symm_pad_source.sv
// Frame-edge padding source: wraps an IMG_W x IMG_W raster with a PAD-wide constant border.
// Optional PADSRC_FRAME_CNT_EN adds a 16-bit count of accepted end-of-frame pixels.
module symm_pad_source #(
  parameter int         IMG_W   = 512,
  parameter int         PAD     = 1,
  parameter logic [7:0] PAD_VAL = 8'd0
) (
  input logic            clk,
  input logic            reset,
  symm_pad_source_if.slave bus
);
  localparam int STREAM_W = IMG_W + 2 * PAD;
  localparam int CW       = $clog2(STREAM_W);
  localparam logic [CW-1:0] LAST     = CW'(STREAM_W - 1);
  localparam logic [CW-1:0] PAD_M1   = CW'(PAD - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(PAD + IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TOP, S_LEFT, S_PIX, S_RIGHT, S_BOT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] row, col;
  logic          advance, emit, ready_c;
  logic [7:0]    val;
  logic          valid_r, eol_r, eof_r;
  logic [7:0]    y_r;

  assign advance = ~valid_r | bus.i_ready;

  always_comb begin
    state_n = state;
    emit    = 1'b0;
    ready_c = 1'b0;
    val     = PAD_VAL;
    case (state)
      S_IDLE: begin
        if (bus.i_valid) state_n = S_TOP;
      end
      S_TOP: begin
        emit = advance;
        if (advance && col == LAST && row == PAD_M1) state_n = S_LEFT;
      end
      S_LEFT: begin
        emit = advance;
        if (advance && col == PAD_M1) state_n = S_PIX;
      end
      S_PIX: begin
        ready_c = advance;
        emit    = advance & bus.i_valid;
        val     = bus.i_x;
        if (emit && col == PIX_LAST) state_n = S_RIGHT;
      end
      S_RIGHT: begin
        emit = advance;
        if (advance && col == LAST) state_n = (row == PIX_LAST) ? S_BOT : S_LEFT;
      end
      S_BOT: begin
        emit = advance;
        if (advance && col == LAST && row == LAST) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Counters track the position of the pixel being emitted, so they move only with emit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (emit) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      y_r     <= '0;
      eol_r   <= 1'b0;
      eof_r   <= 1'b0;
    end else if (advance) begin
      valid_r <= emit;
      if (emit) begin
        y_r   <= val;
        eol_r <= (col == LAST);
        eof_r <= (col == LAST) && (row == LAST);
      end
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_valid = valid_r;
  assign bus.o_y     = y_r;
  assign bus.o_eol   = eol_r;
  assign bus.o_eof   = eof_r;

`ifdef PADSRC_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (valid_r && bus.i_ready && eof_r) frame_cnt <= frame_cnt + 16'd1;
  end

  assign bus.o_frame_cnt = frame_cnt;
`endif
endmodule

// File: tb/tb_symm_pad_source.sv
// Directed bench for symm_pad_source: 4x4/PAD1 instance plus a 2x2/PAD2/0x80 instance.
module tb_symm_pad_source;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  symm_pad_source_if ifa ();
  symm_pad_source_if ifb ();

  symm_pad_source #(.IMG_W(4), .PAD(1), .PAD_VAL(8'd0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  symm_pad_source #(.IMG_W(2), .PAD(2), .PAD_VAL(8'h80)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          out_idx, next_raw, consumed, exp_cnt;
  logic        held_pend;
  logic [7:0]  held_y;
  logic        held_eol, held_eof;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Padded 6x6 frame f: interior (r,c) in 1..4 carries raw 16*f + (r-1)*4 + c, border is 0.
  function automatic logic [7:0] exp_a(input int k);
    int f, p, r, c;
    f = k / 36; p = k % 36; r = p / 6; c = p % 6;
    if (r >= 1 && r <= 4 && c >= 1 && c <= 4) return 8'(16 * f + (r - 1) * 4 + c);
    return 8'h00;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    ifa.i_valid = 1'b0; ifa.i_ready = 1'b1; ifa.i_x = '0;
    ifb.i_valid = 1'b0; ifb.i_ready = 1'b1; ifb.i_x = '0;
    #1;
    chk("rst_valid", ifa.o_valid, 0);
    chk("rst_ready", ifa.o_ready, 0);
    chk("rst_y",     ifa.o_y, 0);
    chk("rst_eol",   ifa.o_eol, 0);
    chk("rst_eof",   ifa.o_eof, 0);
`ifdef PADSRC_FRAME_CNT_EN
    chk("rst_cnt",   ifa.o_frame_cnt, 0);
`endif
    @(negedge clk);
    chk("rst_valid_next", ifa.o_valid, 0);
    chk("rst_ready_next", ifa.o_ready, 0);
    chk("rst_b_valid",    ifb.o_valid, 0);
    reset = 1'b0;
    out_idx = 0; next_raw = 1; consumed = 0; exp_cnt = 0; held_pend = 1'b0;
    @(negedge clk);
  endtask

  task automatic step_a(input logic v, input logic r, input logic expect_idle);
    ifa.i_valid = v; ifa.i_x = 8'(next_raw); ifa.i_ready = r;
    #1;
    if (held_pend) begin
      chk("hold_valid", ifa.o_valid, 1);
      chk("hold_y",     ifa.o_y, held_y);
      chk("hold_eol",   ifa.o_eol, held_eol);
      chk("hold_eof",   ifa.o_eof, held_eof);
    end
    held_pend = ifa.o_valid && !ifa.i_ready;
    held_y = ifa.o_y; held_eol = ifa.o_eol; held_eof = ifa.o_eof;
    if (expect_idle) chk("gap_drain", ifa.o_valid, 0);
`ifdef PADSRC_FRAME_CNT_EN
    chk("frame_cnt", ifa.o_frame_cnt, exp_cnt);
`endif
    if (ifa.o_valid && ifa.i_ready) begin
      chk("y",   ifa.o_y, exp_a(out_idx));
      chk("eol", ifa.o_eol, (out_idx % 6) == 5);
      chk("eof", ifa.o_eof, (out_idx % 36) == 35);
      if ((out_idx % 36) == 35) exp_cnt++;
      out_idx++;
    end
    if (ifa.i_valid && ifa.o_ready) begin
      next_raw++;
      consumed++;
    end
    @(negedge clk);
  endtask

  // mode 0: ready always high; 1: ready toggles; 2: 5-cycle i_valid gap after raw 5.
  task automatic run_a(input int n_out, input int mode);
    int gap_left;
    gap_left = 5;
    for (int cyc = 0; cyc < 1000 && out_idx < n_out; cyc++) begin
      if (mode == 2 && next_raw == 6 && gap_left > 0) begin
        step_a(1'b0, 1'b1, gap_left <= 4);
        gap_left--;
      end else begin
        step_a(1'b1, (mode == 1) ? ((cyc % 2) == 0) : 1'b1, 1'b0);
      end
    end
    chk("out_count", out_idx, n_out);
  endtask

  initial begin
    int bidx, braw, bcons, r, c;
    logic [7:0] bexp;

    @(negedge clk);
    apply_reset();

    // 1: free-running frame
    run_a(36, 0);
    chk("consumed_t1", consumed, 16);

    // 2: downstream ready toggling
    apply_reset();
    run_a(36, 1);
    chk("consumed_t2", consumed, 16);

    // 3: upstream gap mid row 2
    apply_reset();
    run_a(36, 2);
    chk("consumed_t3", consumed, 16);

    // 4: two frames back-to-back
    apply_reset();
    run_a(72, 0);
    chk("consumed_t4", consumed, 32);
`ifdef PADSRC_FRAME_CNT_EN
    chk("frame_cnt_end", ifa.o_frame_cnt, 2);
`endif

    // 5: reset mid-frame, then a clean frame
    apply_reset();
    run_a(20, 0);
    apply_reset();
    run_a(36, 0);
    chk("consumed_t5", consumed, 16);

    // 6: IMG_W=2, PAD=2, PAD_VAL=0x80
    apply_reset();
    bidx = 0; braw = 1; bcons = 0;
    for (int cyc = 0; cyc < 500 && bidx < 36; cyc++) begin
      ifb.i_valid = 1'b1; ifb.i_x = 8'(braw); ifb.i_ready = 1'b1;
      #1;
      if (ifb.o_valid) begin
        r = bidx / 6; c = bidx % 6;
        bexp = (r >= 2 && r <= 3 && c >= 2 && c <= 3) ? 8'((r - 2) * 2 + (c - 2) + 1) : 8'h80;
        chk("b_y",   ifb.o_y, bexp);
        chk("b_eol", ifb.o_eol, c == 5);
        chk("b_eof", ifb.o_eof, bidx == 35);
        bidx++;
      end
      if (ifb.i_valid && ifb.o_ready) begin
        braw++;
        bcons++;
      end
      @(negedge clk);
    end
    chk("b_out_count", bidx, 36);
    chk("b_consumed", bcons, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
